// File: rtl/regfile_wr_decoder.sv
// Registered multi-port write-select decoder with a pending-write busy scoreboard.
// The highest-index port wins a same-address collision, and the zero register is never selected.
module regfile_wr_decoder #(
  parameter int INPUT_WIDTH = 5,
  parameter int NUM_PORTS   = 2,
  parameter int ZERO_REG    = 31
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 wr_en,
  input  logic [NUM_PORTS*INPUT_WIDTH-1:0]     wr_addr,
  input  logic                                 rsv_en,
  input  logic [INPUT_WIDTH-1:0]               rsv_addr,
  output logic [NUM_PORTS*(2**INPUT_WIDTH)-1:0] sel,
  output logic                                 conflict,
  output logic [(2**INPUT_WIDTH)-1:0]          busy,
  output logic                                 any_busy
);

  localparam int NREG = 2**INPUT_WIDTH;
  localparam logic [INPUT_WIDTH-1:0] ZERO_ADDR = INPUT_WIDTH'(ZERO_REG);

  logic [NUM_PORTS-1:0]      valid;
  logic [NUM_PORTS-1:0]      keep;
  logic [NUM_PORTS*NREG-1:0] sel_next;
  logic [NREG-1:0]           clear_vec;
  logic [NREG-1:0]           set_vec;
  logic [NREG-1:0]           busy_next;
  logic                      conflict_next;

  always_comb begin
    valid     = '0;
    keep      = '0;
    sel_next  = '0;
    clear_vec = '0;
    set_vec   = '0;

    for (int p = 0; p < NUM_PORTS; p++) begin
      valid[p] = wr_en[p] && (wr_addr[p*INPUT_WIDTH +: INPUT_WIDTH] != ZERO_ADDR);
    end

    // A valid port survives only if no higher-index valid port targets the same register.
    for (int p = 0; p < NUM_PORTS; p++) begin
      keep[p] = valid[p];
      for (int q = p + 1; q < NUM_PORTS; q++) begin
        if (valid[q] && (wr_addr[q*INPUT_WIDTH +: INPUT_WIDTH] ==
                         wr_addr[p*INPUT_WIDTH +: INPUT_WIDTH])) begin
          keep[p] = 1'b0;
        end
      end
      if (keep[p]) begin
        sel_next[p*NREG +: NREG] = NREG'(1) << wr_addr[p*INPUT_WIDTH +: INPUT_WIDTH];
      end
      clear_vec = clear_vec | sel_next[p*NREG +: NREG];
    end

    conflict_next = |(valid & ~keep);

    if (rsv_en && (rsv_addr != ZERO_ADDR)) begin
      set_vec = NREG'(1) << rsv_addr;
    end

    // A new reservation outranks the retirement of the previous producer.
    busy_next = (busy & ~clear_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel      <= '0;
      conflict <= 1'b0;
      busy     <= '0;
    end else begin
      sel      <= sel_next;
      conflict <= conflict_next;
      busy     <= busy_next;
    end
  end

  assign any_busy = |busy;

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// Scoreboard bench for regfile_wr_decoder: default (5,2,31) instance plus a (3,3,7) width-sweep instance.
module tb_regfile_wr_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a;
  logic [1:0]  en_a;
  logic [9:0]  addr_a;
  logic        rsv_a;
  logic [4:0]  raddr_a;
  logic [63:0] sel_a;
  logic        conf_a;
  logic [31:0] busy_a;
  logic        anyb_a;

  logic        rst_b;
  logic [2:0]  en_b;
  logic [8:0]  addr_b;
  logic        rsv_b;
  logic [2:0]  raddr_b;
  logic [23:0] sel_b;
  logic        conf_b;
  logic [7:0]  busy_b;
  logic        anyb_b;

  regfile_wr_decoder #(.INPUT_WIDTH(5), .NUM_PORTS(2), .ZERO_REG(31)) dut_a (
    .clk(clk), .reset(rst_a), .wr_en(en_a), .wr_addr(addr_a), .rsv_en(rsv_a),
    .rsv_addr(raddr_a), .sel(sel_a), .conflict(conf_a), .busy(busy_a), .any_busy(anyb_a)
  );

  regfile_wr_decoder #(.INPUT_WIDTH(3), .NUM_PORTS(3), .ZERO_REG(7)) dut_b (
    .clk(clk), .reset(rst_b), .wr_en(en_b), .wr_addr(addr_b), .rsv_en(rsv_b),
    .rsv_addr(raddr_b), .sel(sel_b), .conflict(conf_b), .busy(busy_b), .any_busy(anyb_b)
  );

  typedef struct packed {
    logic [127:0] sel;
    logic         conflict;
    logic [31:0]  busy;
    logic         any_busy;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] mdl_busy_a;
  logic [31:0] mdl_busy_b;
  int          checks;
  int          failures;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Walk ports from highest index down; the first claimant of a register owns it.
  function automatic exp_t model(input int iw, input int np, input int zr,
                                 input logic [3:0] en, input logic [19:0] addr,
                                 input logic rsv, input logic [4:0] raddr,
                                 input logic rst, input logic [31:0] bprev);
    exp_t        e;
    logic [31:0] claimed;
    int          nreg;
    int          a;
    e       = '0;
    claimed = '0;
    nreg    = 1 << iw;
    if (rst) return e;
    for (int p = np - 1; p >= 0; p--) begin
      if (en[p]) begin
        a = int'(addr[p*5 +: 5]);
        if (a != zr) begin
          if (claimed[a]) e.conflict = 1'b1;
          else begin
            claimed[a]          = 1'b1;
            e.sel[p*nreg + a]   = 1'b1;
          end
        end
      end
    end
    for (int r = 0; r < nreg; r++) begin
      if (rsv && int'(raddr) == r && r != zr) e.busy[r] = 1'b1;
      else if (claimed[r])                    e.busy[r] = 1'b0;
      else                                    e.busy[r] = bprev[r];
    end
    e.any_busy = |e.busy;
    return e;
  endfunction

  task automatic step_a(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                        input logic rsv, input logic [4:0] raddr, input logic rst);
    exp_t e;
    rst_a = rst; en_a = en; addr_a = {a1, a0}; rsv_a = rsv; raddr_a = raddr;
    e = model(5, 2, 31, {2'b00, en}, {10'd0, a1, a0}, rsv, raddr, rst, mdl_busy_a);
    mdl_busy_a = e.busy;
    q_a.push_back(e);
    @(posedge clk);
    #1;
    if (q_a.size() == 0) begin
      check_val("a_queue_empty", 128'(1), 128'(0));
    end else begin
      e = q_a.pop_front();
      check_val("a_sel", 128'(sel_a), e.sel);
      check_val("a_conflict", 128'(conf_a), 128'(e.conflict));
      check_val("a_busy", 128'(busy_a), 128'(e.busy));
      check_val("a_any_busy", 128'(anyb_a), 128'(e.any_busy));
    end
  endtask

  task automatic step_b(input logic [2:0] en, input logic [2:0] a0, input logic [2:0] a1,
                        input logic [2:0] a2, input logic rsv, input logic [2:0] raddr,
                        input logic rst);
    exp_t e;
    rst_b = rst; en_b = en; addr_b = {a2, a1, a0}; rsv_b = rsv; raddr_b = raddr;
    e = model(3, 3, 7, {1'b0, en}, {5'd0, 2'b00, a2, 2'b00, a1, 2'b00, a0},
              rsv, {2'b00, raddr}, rst, mdl_busy_b);
    mdl_busy_b = e.busy;
    q_b.push_back(e);
    @(posedge clk);
    #1;
    if (q_b.size() == 0) begin
      check_val("b_queue_empty", 128'(1), 128'(0));
    end else begin
      e = q_b.pop_front();
      check_val("b_sel", 128'(sel_b), e.sel);
      check_val("b_conflict", 128'(conf_b), 128'(e.conflict));
      check_val("b_busy", 128'(busy_b), 128'(e.busy[7:0]));
      check_val("b_any_busy", 128'(anyb_b), 128'(e.any_busy));
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    mdl_busy_a = '0; mdl_busy_b = '0;
    rst_a = 1'b1; en_a = '0; addr_a = '0; rsv_a = 1'b0; raddr_a = '0;
    rst_b = 1'b1; en_b = '0; addr_b = '0; rsv_b = 1'b0; raddr_b = '0;

    step_a(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);

    // Preload busy, then reset with write and reserve requests on the same edge
    step_a(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
    step_a(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
    check_val("preload_busy", 128'(busy_a), 128'(32'h0000_0208));
    step_a(2'b11, 5'd5, 5'd6, 1'b1, 5'd12, 1'b1);
    check_val("reset_sel", 128'(sel_a), 128'(0));
    check_val("reset_busy", 128'(busy_a), 128'(0));
    check_val("reset_any_busy", 128'(anyb_a), 128'(0));

    step_a(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    check_val("wr5_port0", 128'(sel_a[31:0]), 128'(32'h0000_0020));
    check_val("wr5_port1", 128'(sel_a[63:32]), 128'(0));
    step_a(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    check_val("wr5_pulse_end", 128'(sel_a), 128'(0));

    step_a(2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
    check_val("x7_port1", 128'(sel_a[63:32]), 128'(32'h0000_0080));
    check_val("x7_port0", 128'(sel_a[31:0]), 128'(0));
    check_val("x7_conflict", 128'(conf_a), 128'(1));
    step_a(2'b11, 5'd7, 5'd8, 1'b0, 5'd0, 1'b0);
    check_val("x7x8_conflict", 128'(conf_a), 128'(0));
    check_val("x7x8_sel", 128'(sel_a), 128'(64'h0000_0100_0000_0080));

    step_a(2'b01, 5'd31, 5'd0, 1'b1, 5'd31, 1'b0);
    check_val("zero_sel", 128'(sel_a), 128'(0));
    check_val("zero_busy31", 128'(busy_a[31]), 128'(0));
    step_a(2'b11, 5'd31, 5'd31, 1'b0, 5'd0, 1'b0);
    check_val("zero_both_conflict", 128'(conf_a), 128'(0));

    step_a(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
    check_val("rsv3_busy", 128'(busy_a[3]), 128'(1));
    check_val("rsv3_any", 128'(anyb_a), 128'(1));
    step_a(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step_a(2'b10, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0);
    check_val("wr3_clear", 128'(busy_a[3]), 128'(0));
    step_a(2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0);
    check_val("rsv_wr_same", 128'(busy_a[3]), 128'(1));
    step_a(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
    check_val("rsv_again", 128'(busy_a[3]), 128'(1));

    step_a(2'b01, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
    check_val("b2b_first", 128'(sel_a[4]), 128'(1));
    step_a(2'b01, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
    check_val("b2b_second", 128'(sel_a[4]), 128'(1));

    // Mid-sequence reset with busy bits and sel active
    step_a(2'b01, 5'd11, 5'd0, 1'b1, 5'd10, 1'b0);
    step_a(2'b11, 5'd10, 5'd12, 1'b1, 5'd13, 1'b1);
    check_val("mid_reset_busy", 128'(busy_a), 128'(0));
    step_a(2'b01, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      step_a(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 19) == 0));
    end
    step_a(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);

    step_b(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1);
    step_b(3'b111, 3'd2, 3'd2, 3'd2, 1'b0, 3'd0, 1'b0);
    check_val("w3_sel", 128'(sel_b), 128'(24'h04_0000));
    check_val("w3_conflict", 128'(conf_b), 128'(1));
    for (int p = 0; p < 3; p++) begin
      for (int a = 0; a < 8; a++) begin
        step_b(3'(1 << p), 3'(a), 3'(a), 3'(a), 1'b0, 3'd0, 1'b0);
        check_val("w3_onehot", 128'($countones(sel_b)), (a == 7) ? 128'(0) : 128'(1));
      end
    end
    step_b(3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0);
    step_b(3'b011, 3'd5, 3'd5, 3'd0, 1'b1, 3'd7, 1'b0);
    check_val("w3_busy5_cleared", 128'(busy_b[5]), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
